// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one 8N1 UART transmitter among N_REQ byte-stream requesters.
// Optional per-frame timeout is compiled in when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 24000,
    parameter int unsigned TO_W           = 16
) (
    input  logic                      hwclk,
    input  logic                      rst_n,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [N_REQ-1:0]          req_last,
    output logic [N_REQ-1:0]          req_ready,
    output logic [N_REQ-1:0]          grant,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_done,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [1:0]                state_dbg
);

    localparam int unsigned PTR_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic [N_REQ-1:0]    grant_q, grant_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic                tx_start_q, tx_start_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                last_q, last_d;

    logic                pick_found;
    logic [N_REQ-1:0]    pick_oh;
    logic [PTR_W-1:0]    pick_idx;

    logic                own_valid;
    logic                own_last;
    logic [DATA_W-1:0]   own_data;

    logic                to_hit;

    // Unreachable in a legal build; its presence in the hierarchy flags a bad parameter set.
    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 2 ||
        TIMEOUT_CYCLES > (64'd1 << TO_W)) begin : g_cfg_out_of_range
    end

    // Search ptr+1 .. ptr+N_REQ modulo N_REQ: first the indices above ptr, then wrap to 0..ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_oh    = '0;
        pick_idx   = '0;
        for (int j = 0; j < int'(N_REQ); j++) begin
            if (!pick_found && req_valid[j] && (PTR_W'(j) > ptr_q)) begin
                pick_found = 1'b1;
                pick_oh[j] = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
        for (int j = 0; j < int'(N_REQ); j++) begin
            if (!pick_found && req_valid[j] && (PTR_W'(j) <= ptr_q)) begin
                pick_found = 1'b1;
                pick_oh[j] = 1'b1;
                pick_idx   = PTR_W'(j);
            end
        end
    end

    always_comb begin
        own_valid = |(req_valid & grant_q);
        own_last  = |(req_last & grant_q);
        own_data  = '0;
        for (int j = 0; j < int'(N_REQ); j++) begin
            if (grant_q[j]) begin
                own_data = own_data | req_data[j*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= PTR_W'(N_REQ - 1);
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            last_q     <= last_d;
        end
    end

    // Handshake: a byte moves when req_valid[i] and req_ready[i] are both high at a rising edge;
    // req_ready depends only on registered state, never on req_valid, and data/last are
    // sampled on that edge alone.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        last_d     = last_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    grant_d = pick_oh;
                    ptr_d   = pick_idx;
                    state_d = ST_SEND;
                end
            end
            ST_SEND: begin
                if (own_valid) begin
                    tx_data_d  = own_data;
                    last_d     = own_last;
                    tx_start_d = 1'b1;
                    state_d    = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        grant_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SEND;
                    end
                end else if (to_hit) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                grant_d = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        req_ready = (state_q == ST_SEND) ? grant_q : '0;
        busy      = (state_q != ST_IDLE);
        grant     = grant_q;
        tx_start  = tx_start_q;
        tx_data   = tx_data_q;
        state_dbg = state_q;
    end

`ifdef UART_ARB_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            to_err_q;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q == ST_SEND && own_valid) begin
            to_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    // A tx_done landing on the terminal count completes the frame normally.
    assign to_hit = (state_q == ST_WAIT) && (to_cnt_q == TO_LAST) && !tx_done;

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt_q <= '0;
            to_err_q <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            to_err_q <= to_hit;
        end
    end

    assign timeout_err = to_err_q;
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized message traffic
// scored against a message-level round-robin model.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TO_CYC = 64;
  localparam int T1_DLY = 40;
`else
  localparam int TO_CYC = 24000;
  localparam int T1_DLY = 100;
`endif
  localparam int SB_W = N + 1 + DW;

  logic          hwclk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req_valid, req_last, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic          tx_start, tx_done, busy, timeout_err;
  logic [DW-1:0] tx_data;
  logic [1:0]    state_dbg;

  always #5 hwclk = ~hwclk;

  uart_tx_arbiter #(
    .N_REQ(N), .DATA_W(DW), .TIMEOUT_CYCLES(TO_CYC), .TO_W(16)
  ) dut (
    .hwclk(hwclk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
    .busy(busy), .timeout_err(timeout_err), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  logic [DW:0] rq [N][$];          // per-requester pending bytes {last, data}
  logic [SB_W-1:0] exp_q[$];       // expected frames {grant, last, data}
  logic [N-1:0] at_start = '1;
  logic [N-1:0] hold = '0;
  bit stall_en = 0;
  int m_ptr = N - 1;
  int cyc = 0;
  int tx_mode = -1;
  bit tx_never = 0;
  bit tx_pending = 0;
  int tx_cnt = 0;
  logic [DW-1:0] tx_held;
  bit tx_last_cur = 0;
  logic [N-1:0] tx_owner_cur = '0;
  logic [N-1:0] owner_prev = '0;
  int n_tx_start = 0;
  int to_seen = 0;
  bit hs_prev = 0, done_last_prev = 0, done_mid_prev = 0, idle_req_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_empty();
    bit e = 1;
    for (int i = 0; i < N; i++) if (rq[i].size() != 0) e = 0;
    return e;
  endfunction

  // One clock cycle: observe outputs at the falling edge, then drive this cycle's inputs.
  task automatic tick();
    logic [SB_W-1:0] e;
    logic [DW:0] hd;
    logic v;
    @(negedge hwclk);
    cyc++;
    if (hs_prev || tx_start) check("tx_start_after_handshake", 32'(tx_start), 32'(hs_prev));
    if (done_last_prev) check("idle_after_last_done", {busy, grant}, 0);
    if (done_mid_prev) check("ready_after_mid_done", req_ready, owner_prev);
    if (idle_req_prev) check("grant_after_idle_req", 32'(busy), 1);
    if (timeout_err) begin
      to_seen++;
      tx_pending = 0;
    end
    if (tx_start) begin
      n_tx_start++;
      check("sb_pending", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("tx_grant", grant, e[SB_W-1 -: N]);
        check("tx_data", tx_data, e[DW-1:0]);
        tx_last_cur  = e[DW];
        tx_owner_cur = e[SB_W-1 -: N];
      end else begin
        tx_last_cur  = 1;
        tx_owner_cur = '0;
      end
      tx_pending = 1;
      tx_held    = tx_data;
      tx_cnt     = tx_never ? (1 << 30) : (tx_mode >= 0 ? tx_mode : int'($urandom_range(0, 8)));
    end
    tx_done = 0;
    done_last_prev = 0;
    done_mid_prev  = 0;
    if (tx_pending) begin
      if (tx_cnt == 0) begin
        tx_done    = 1;
        tx_pending = 0;
        check("tx_data_stable", tx_data, tx_held);
        if (tx_last_cur) done_last_prev = 1;
        else begin
          done_mid_prev = 1;
          owner_prev    = tx_owner_cur;
        end
      end else begin
        tx_cnt--;
      end
    end
    hs_prev = 0;
    for (int i = 0; i < N; i++) begin
      v = (rq[i].size() != 0) && !hold[i];
      if (v && !at_start[i] && stall_en && $urandom_range(0, 2) == 0) v = 0;
      req_valid[i] = v;
      if (rq[i].size() != 0) begin
        hd = rq[i][0];
        req_data[i*DW +: DW] = hd[DW-1:0];
        req_last[i] = hd[DW];
      end else begin
        req_data[i*DW +: DW] = 8'($urandom);
        req_last[i] = 1'($urandom_range(0, 1));
      end
      if (v && req_ready[i]) begin
        hd = rq[i].pop_front();
        at_start[i] = hd[DW];
        hs_prev = 1;
      end
    end
    idle_req_prev = !busy && (req_valid != '0);
  endtask

  // Message-level round robin: next requester after the last winner that has anything queued
  // sends its whole message.
  task automatic model_load();
    logic [DW:0] cp [N][$];
    logic [DW:0] hd;
    logic [N-1:0] oh;
    int w;
    for (int k = 0; k < N; k++) cp[k] = rq[k];
    for (int guard = 0; guard < 1000; guard++) begin
      w = -1;
      for (int s = 1; s <= N; s++)
        if (w < 0 && cp[(m_ptr + s) % N].size() != 0) w = (m_ptr + s) % N;
      if (w < 0) break;
      m_ptr = w;
      oh = '0;
      oh[w] = 1'b1;
      do begin
        hd = cp[w].pop_front();
        exp_q.push_back({oh, hd});
      end while (!hd[DW] && cp[w].size() != 0);
    end
  endtask

  task automatic push_rand_msg(input int r, input int len);
    for (int b = 0; b < len; b++) rq[r].push_back({1'(b == len - 1), 8'($urandom)});
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (!(exp_q.size() == 0 && all_empty() && !tx_pending && !busy) && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_drained_in_budget"}, 32'(n < budget), 1);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  task automatic wait_tx_start(input int budget, input string tag);
    int base = n_tx_start;
    int n = 0;
    while (n_tx_start == base && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_tx_start_seen"}, 32'(n_tx_start != base), 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d expected finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int base, e_cyc, tbase;
    logic [SB_W-1:0] ent;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;

    // Reset and reset values
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_grant", grant, 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_tx_start", 32'(tx_start), 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_req_ready", req_ready, 0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    check("rst_state", state_dbg, 0);

    // All four requesters at once, twice: order 0,1,2,3 both rounds
    for (int r = 0; r < N; r++) rq[r].push_back({1'b1, 8'(8'h10 + r)});
    model_load();
    wait_idle(400, "rr_round1");
    for (int r = 0; r < N; r++) rq[r].push_back({1'b1, 8'(8'h20 + r)});
    model_load();
    wait_idle(400, "rr_round2");

    // Single requester, 3-byte message, slow transmitter
    tx_mode = T1_DLY;
    base = n_tx_start;
    rq[0].push_back({1'b0, 8'h48});
    rq[0].push_back({1'b0, 8'h69});
    rq[0].push_back({1'b1, 8'h0A});
    model_load();
    wait_idle(1000, "single_msg");
    check("single_msg_starts", n_tx_start - base, 3);
    check("single_msg_state_idle", state_dbg, 0);

    // Requester 2 raises valid while requester 1 is mid-message
    tx_mode = 20;
    push_rand_msg(1, 3);
    model_load();
    wait_tx_start(50, "mid_msg");
    rq[2].push_back({1'b1, 8'hC2});
    ent = {4'b0100, 1'b1, 8'hC2};
    exp_q.push_back(ent);
    m_ptr = 2;
    repeat (25) tick();
    check("mid_msg_grant_held", grant, 4'b0010);
    wait_idle(400, "mid_msg");

    // Owner stalls 50 cycles mid-message while another requester waits
    tx_mode = -1;
    push_rand_msg(3, 2);
    push_rand_msg(0, 1);
    model_load();
    wait_tx_start(50, "stall");
    hold[3] = 1'b1;
    base = n_tx_start;
    repeat (50) tick();
    check("stall_no_tx_start", n_tx_start - base, 0);
    check("stall_grant_held", grant, 4'b1000);
    check("stall_ready_held", req_ready, 4'b1000);
    hold[3] = 1'b0;
    wait_idle(200, "stall");

    // Randomized traffic with mid-message stalls and random frame times
    stall_en = 1;
    for (int round = 0; round < 12; round++) begin
      for (int r = 0; r < N; r++)
        if ($urandom_range(0, 1) == 1)
          for (int m = 0; m < int'($urandom_range(1, 2)); m++) push_rand_msg(r, $urandom_range(1, 4));
      model_load();
      wait_idle(3000, "random");
    end
    stall_en = 0;

`ifdef UART_ARB_TIMEOUT_EN
    // Frame never completes: abort 64 cycles after WAIT entry
    tx_never = 1;
    push_rand_msg(1, 1);
    model_load();
    wait_tx_start(50, "timeout");
    e_cyc = cyc;
    tbase = to_seen;
    for (int n = 0; n < 200 && to_seen == tbase; n++) tick();
    check("timeout_pulse_seen", to_seen - tbase, 1);
    check("timeout_latency", cyc - e_cyc, 64);
    check("timeout_grant_clear", grant, 0);
    check("timeout_busy_clear", 32'(busy), 0);
    tick();
    check("timeout_one_cycle", 32'(timeout_err), 0);
    tx_never = 0;
    // tx_done on the terminal cycle wins
    tx_mode = 63;
    tbase = to_seen;
    push_rand_msg(2, 1);
    model_load();
    wait_idle(200, "timeout_terminal");
    check("timeout_terminal_no_err", to_seen - tbase, 0);
    tx_mode = -1;
`else
    check("timeout_never_pulsed", to_seen, 0);
`endif

    // Asynchronous reset in the middle of a frame
    tx_mode = 100;
    push_rand_msg(2, 1);
    model_load();
    wait_tx_start(50, "reset_wait");
    rst_n = 1'b0;
    #1;
    check("arst_tx_start", 32'(tx_start), 0);
    check("arst_grant", grant, 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_req_ready", req_ready, 0);
    check("arst_state", state_dbg, 0);
    exp_q.delete();
    for (int r = 0; r < N; r++) rq[r].delete();
    tx_pending = 0;
    hs_prev = 0;
    done_last_prev = 0;
    done_mid_prev = 0;
    idle_req_prev = 0;
    at_start = '1;
    m_ptr = N - 1;
    tx_mode = -1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int r = N - 1; r >= 0; r--) rq[r].push_back({1'b1, 8'(8'h30 + r)});
    model_load();
    wait_idle(400, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
